// File: rtl/mdio_pkg.sv
// MDIO master shared definitions.
// Frame constants, FSM states, request bundle.
package mdio_pkg;

  localparam logic [1:0] ST_C    = 2'b01;
  localparam logic [1:0] OP_WR_C = 2'b01;
  localparam logic [1:0] OP_RD_C = 2'b10;

  localparam int HDR_BITS  = 14;
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } mdio_state_e;

  typedef struct packed {
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mdio_req_t;

  // 32-bit frame after the preamble, MSB first.
  // Read frames carry all-ones past the header;
  // those bits are never driven.
  function automatic logic [31:0] build_frame(
    input mdio_req_t r
  );
    return {ST_C,
            r.write ? OP_WR_C : OP_RD_C,
            r.phy,
            r.regad,
            r.write ? {2'b10, r.wdata} : 18'h3ffff};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator for the MDIO master.
// Ports: clk_i, rst_i, enable -> mdc, fall_stb, sample_stb.
module mdio_clk_gen
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable,
  output logic mdc,
  output logic fall_stb,
  output logic sample_stb
);

  localparam logic [9:0] LAST = 10'(CLK_DIV - 1);

  logic [9:0] cnt_q;
  logic       high_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      high_q <= ~high_q;
    end else begin
      cnt_q <= cnt_q + 10'd1;
    end
  end

  assign mdc        = enable & high_q;
  assign fall_stb   = enable & ~high_q & (cnt_q == '0);
  assign sample_stb = enable & high_q & (cnt_q == LAST);

endmodule

// File: rtl/mdio_master_ctrl.sv
// Clause-22 MDIO master: one frame in flight.
// Ports: req_* command in, rsp_* completion out, busy_o, mdc_o/mdio_* pad side.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 25,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [4:0]  req_phy_i,
  input  logic [4:0]  req_reg_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  localparam logic [5:0] PRE_LAST =
    (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;
  localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

  mdio_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [14:0] rx_q, rx_d;
  logic [15:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic        rerr_q, rerr_d;
  logic        rvld_q, rvld_d;
  logic        mdo_q, mdo_d;
  logic        oe_q, oe_d;

  logic        clk_en;
  logic        sample_stb;
  logic        fall_stb_unused;
  logic        last;
  logic        data_bit;
  logic [31:0] tx_shift;
  logic [31:0] frame;
  mdio_req_t   req;

  assign req.write = req_write_i;
  assign req.phy   = req_phy_i;
  assign req.regad = req_reg_i;
  assign req.wdata = req_wdata_i;
  assign frame     = build_frame(req);

  assign clk_en = state_q inside {S_PRE, S_HDR, S_TA, S_DATA};
  assign last   = (cnt_q == 6'd0);

  // Outputs are loaded on the edge that opens a bit
  // period, so they change on its first (falling) cycle.
  assign tx_shift = {tx_q[30:0], 1'b0};
  assign data_bit = wr_q ? tx_q[31] : 1'b1;

  mdio_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .enable    (clk_en),
    .mdc       (mdc_o),
    .fall_stb  (fall_stb_unused),
    .sample_stb(sample_stb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rerr_d  = rerr_q;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    mdo_d   = mdo_q;
    oe_d    = oe_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          wr_d  = req_write_i;
          err_d = 1'b0;
          rx_d  = '0;
          oe_d  = 1'b1;
          if (PREAMBLE_LEN > 0) begin
            state_d = S_PRE;
            cnt_d   = PRE_LAST;
            mdo_d   = 1'b1;
            tx_d    = frame;
          end else begin
            state_d = S_HDR;
            cnt_d   = HDR_LAST;
            mdo_d   = frame[31];
            tx_d    = {frame[30:0], 1'b0};
          end
        end
      end
      S_PRE: begin
        if (sample_stb) begin
          if (last) begin
            state_d = S_HDR;
            cnt_d   = HDR_LAST;
            mdo_d   = tx_q[31];
            tx_d    = tx_shift;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      S_HDR: begin
        if (sample_stb) begin
          tx_d = tx_shift;
          if (last) begin
            state_d = S_TA;
            cnt_d   = 6'd1;
            oe_d    = wr_q;
            mdo_d   = data_bit;
          end else begin
            cnt_d = cnt_q - 6'd1;
            mdo_d = tx_q[31];
          end
        end
      end
      S_TA: begin
        if (sample_stb) begin
          tx_d  = tx_shift;
          mdo_d = data_bit;
          if (last) begin
            // PHY must pull the second TA bit low.
            err_d   = ~wr_q & mdio_i;
            state_d = S_DATA;
            cnt_d   = DATA_LAST;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      S_DATA: begin
        if (sample_stb) begin
          rx_d = {rx_q[13:0], mdio_i};
          if (last) begin
            state_d = S_DONE;
            mdo_d   = 1'b1;
            oe_d    = 1'b0;
            rvld_d  = 1'b1;
            rerr_d  = err_q;
            if (wr_q)
              rdata_d = 16'h0000;
            else if (err_q)
              rdata_d = 16'hffff;
            else
              rdata_d = {rx_q, mdio_i};
          end else begin
            cnt_d = cnt_q - 6'd1;
            mdo_d = data_bit;
            tx_d  = tx_shift;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rerr_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      mdo_q   <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rerr_q  <= rerr_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      mdo_q   <= mdo_d;
      oe_q    <= oe_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = rvld_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = rerr_q;
  assign mdio_o      = mdo_q;
  assign mdio_oe_o   = oe_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Scoreboard bench for mdio_master_ctrl.
// Two configurations: CLK_DIV=2/PRE=32 and CLK_DIV=1/PRE=0.
module tb_mdio_master_ctrl;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          due;
    int          nbits;
    logic [63:0] bits;
    logic [63:0] oe;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  // Bit k of the wire sequence, first bit at index 0.
  // For reads d is the data the PHY returns.
  function automatic exp_t ref_frame(
    input logic        w,
    input logic [4:0]  pa,
    input logic [4:0]  ra,
    input logic [15:0] d,
    input logic        pres,
    input int          p,
    input int          due
  );
    exp_t        e;
    logic [31:0] body;
    int          idx;
    body = {2'b01, (w ? 2'b01 : 2'b10), pa, ra,
            (w ? {2'b10, d} : 18'h0)};
    e.bits  = '0;
    e.oe    = '0;
    e.nbits = p + 32;
    e.due   = due;
    for (int k = 0; k < p + 32; k++) begin
      if (k < p) begin
        e.bits[k] = 1'b1;
        e.oe[k]   = 1'b1;
      end else begin
        idx       = k - p;
        e.bits[k] = body[31 - idx];
        e.oe[k]   = w || (idx < 14);
      end
    end
    e.rdata = w ? 16'h0 : (pres ? d : 16'hffff);
    e.err   = !w && !pres;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int D = (g == 0) ? 2 : 1;
    localparam int P = (g == 0) ? 32 : 0;
    localparam int FRAME = 1 + (P + 32) * 2 * D;

    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [4:0]  req_phy = '0;
    logic [4:0]  req_reg = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic        mdc, mdo, moe;
    logic [15:0] rsp_rdata;
    logic        mdi = 1'b1;

    mdio_master_ctrl #(
      .CLK_DIV(D),
      .PREAMBLE_LEN(P)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_write_i(req_write),
      .req_phy_i  (req_phy),
      .req_reg_i  (req_reg),
      .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid),
      .rsp_rdata_o(rsp_rdata),
      .rsp_err_o  (rsp_err),
      .busy_o     (busy),
      .mdc_o      (mdc),
      .mdio_o     (mdo),
      .mdio_oe_o  (moe),
      .mdio_i     (mdi)
    );

    exp_t        exp_q[$];
    int          ncap = 0;
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    int          acc_cyc = 0;
    int          rsp_cyc = 0;
    logic [63:0] cap_b = '0;
    logic [63:0] cap_o = '0;
    logic        prev_mdc = 1'b0;
    logic        cur_rd = 1'b0;
    logic        cur_pres = 1'b0;
    logic [15:0] cur_data = '0;
    logic        present = 1'b1;
    logic        done_g = 1'b0;

    // Acceptance -> push expectation; MDC rise ->
    // capture pins and play the PHY; rsp -> compare.
    always @(negedge clk) begin : observer
      exp_t e;
      if (rst) begin
        exp_q.delete();
        ncap     = 0;
        prev_mdc = 1'b0;
        mdi      = 1'b1;
      end else begin
        if (req_valid && req_ready) begin
          exp_q.push_back(ref_frame(req_write, req_phy,
            req_reg, req_wdata, present, P, cyc + FRAME));
          cur_rd   = !req_write;
          cur_pres = present;
          cur_data = req_wdata;
          ncap     = 0;
          cap_b    = '0;
          cap_o    = '0;
          mdi      = 1'b1;
          acc_cnt++;
          acc_cyc  = cyc;
        end
        if (mdc && !prev_mdc && ncap < 64) begin
          cap_b[ncap] = mdo;
          cap_o[ncap] = moe;
          if (cur_rd && cur_pres && ncap == P + 15)
            mdi = 1'b0;
          else if (cur_rd && cur_pres &&
                   ncap >= P + 16 && ncap < P + 32)
            mdi = cur_data[P + 31 - ncap];
          else
            mdi = 1'b1;
          ncap++;
        end
        prev_mdc = mdc;
        if (rsp_valid) begin
          rsp_cnt++;
          rsp_cyc = cyc;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL c%0d unexpected rsp at cycle %0d",
                     g, cyc);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("c%0d rdata", g),
                64'(rsp_rdata), 64'(e.rdata));
            chk($sformatf("c%0d err", g),
                64'(rsp_err), 64'(e.err));
            chk($sformatf("c%0d latency", g),
                64'(cyc), 64'(e.due));
            chk($sformatf("c%0d nbits", g),
                64'(ncap), 64'(e.nbits));
            chk($sformatf("c%0d bits", g),
                cap_b & e.oe, e.bits & e.oe);
            chk($sformatf("c%0d oe", g), cap_o, e.oe);
          end
        end
      end
    end

    task automatic issue(input logic w,
                         input logic [4:0] pa,
                         input logic [4:0] ra,
                         input logic [15:0] d,
                         input logic pres);
      @(posedge clk);
      #1;
      present   = pres;
      req_valid = 1'b1;
      req_write = w;
      req_phy   = pa;
      req_reg   = ra;
      req_wdata = d;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (req_ready) break;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
      int i;
      i = 0;
      while (rsp_cnt < target && i < 4 * FRAME) begin
        @(posedge clk);
        i++;
      end
      if (rsp_cnt < target) begin
        tests++;
        fails++;
        $display("FAIL c%0d rsp timeout: got %0d, need %0d",
                 g, rsp_cnt, target);
      end
    endtask

    task automatic run_one(input logic w,
                           input logic [4:0] pa,
                           input logic [4:0] ra,
                           input logic [15:0] d,
                           input logic pres);
      int base;
      base = rsp_cnt;
      issue(w, pa, ra, d, pres);
      wait_rsp(base + 1);
    endtask

    initial begin : stim
      int base;
      int i;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("c%0d reset ctl", g),
          64'({req_ready, busy, rsp_valid, rsp_err,
               mdc, mdo, moe}),
          64'(7'b1000010));
      chk($sformatf("c%0d reset rdata", g),
          64'(rsp_rdata), 64'(16'h0000));
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_one(1'b1, 5'h01, 5'h00, 16'h8000, 1'b1);
      run_one(1'b0, 5'h03, 5'h02, 16'h1234, 1'b1);
      run_one(1'b0, 5'h07, 5'h11, 16'h5a5a, 1'b0);
      run_one(1'b1, 5'h1f, 5'h1f, 16'hffff, 1'b0);

      // Back-to-back: valid stays high, fields change
      // while the first frame is on the wire.
      base = rsp_cnt;
      @(posedge clk);
      #1;
      present   = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_phy   = 5'h0a;
      req_reg   = 5'h15;
      req_wdata = 16'hc3a5;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (req_ready) break;
      end
      @(posedge clk);
      #1;
      req_phy   = 5'h15;
      req_reg   = 5'h0a;
      req_wdata = 16'h3c5a;
      wait_rsp(base + 1);
      i = 0;
      while (acc_cnt < base + 2 && i < 16) begin
        @(posedge clk);
        i++;
      end
      #1;
      req_valid = 1'b0;
      chk($sformatf("c%0d b2b accept", g),
          64'(acc_cyc), 64'(rsp_cyc + 1));
      wait_rsp(base + 2);

      // Reset in the middle of a read's data phase.
      base = rsp_cnt;
      issue(1'b0, 5'h02, 5'h04, 16'hbeef, 1'b1);
      i = 0;
      while (ncap < P + 20 && i < 4 * FRAME) begin
        @(posedge clk);
        i++;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk($sformatf("c%0d abort pins", g),
          64'({mdc, moe, req_ready}), 64'(3'b001));
      repeat (FRAME + 20) @(posedge clk);
      chk($sformatf("c%0d no rsp after abort", g),
          64'(rsp_cnt), 64'(base));
      run_one(1'b0, 5'h02, 5'h04, 16'h0f0f, 1'b1);

      for (int k = 0; k < 8; k++) begin
        run_one(1'($urandom), 5'($urandom),
                5'($urandom), 16'($urandom),
                ($urandom_range(3) != 0));
      end
      done_g = 1'b1;
    end
  end

  initial begin
    int i;
    i = 0;
    while (!(g_cfg[0].done_g && g_cfg[1].done_g) &&
           i < 50000) begin
      @(posedge clk);
      i++;
    end
    if (!(g_cfg[0].done_g && g_cfg[1].done_g)) begin
      tests++;
      fails++;
      $display("FAIL overall timeout: cycles %0d", i);
    end
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/mdio_master_ctrl.md
Name: mdio_master_ctrl

Overview:
- Sequences IEEE 802.3 Clause-22 management frames on the Ethernet PHY MDIO bus (eth_mdc / eth_mdio pins of the FPGA top).
- Software-side requests arrive on a valid/ready command port from the Ethernet register block.
- The block generates MDC, drives and releases MDIO, and returns read data plus a no-PHY error flag.
- One transaction in flight at a time. The pad tristate buffer sits outside this block.

Parameters:
- CLK_DIV, 25, clk_i cycles per MDC half-period; legal range 1..1023 (50 MHz / 50 = 1 MHz MDC).
- PREAMBLE_LEN, 32, number of leading '1' bits; legal range 0..32.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when valid and ready are both high
- req_write_i  in  1  1 = write (OP=01), 0 = read (OP=10)
- req_phy_i  in  5  PHY address
- req_reg_i  in  5  register address
- req_wdata_i  in  16  write data
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  16  read data; held until the next completion
- rsp_err_o  out  1  read turnaround error (no PHY); held with rsp_rdata_o
- busy_o  out  1  transaction in progress
- mdc_o  out  1  MDIO clock
- mdio_o  out  1  MDIO output value
- mdio_oe_o  out  1  MDIO output enable (1 = drive)
- mdio_i  in  1  MDIO pad input (already synchronised externally)

Behaviour:
- Reset values:
  - req_ready_o=1, busy_o=0, rsp_valid_o=0.
  - rsp_rdata_o=16'h0000, rsp_err_o=0.
  - mdc_o=0, mdio_o=1, mdio_oe_o=0.
  - FSM in IDLE.
- Reset asserted mid-frame aborts immediately to the reset values. No response pulse is generated.
- FSM states and order: IDLE -> PRE -> HDR -> TA -> DATA -> DONE -> IDLE.
  - PRE is skipped when PREAMBLE_LEN=0.
- IDLE:
  - req_ready_o=1.
  - On acceptance, latch all request fields and set busy_o=1 from the next cycle.
  - First bit period starts on the next cycle.
- Bit period: 2*CLK_DIV clk_i cycles.
  - mdc_o=0 for the first CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - mdio_o / mdio_oe_o update only on the first cycle of a bit period (MDC falling edge).
  - mdio_i is sampled on the last cycle of the MDC-high phase.
- PRE: PREAMBLE_LEN bits of '1', oe=1.
- HDR: 14 bits, MSB first, oe=1:
  - ST = 01
  - OP
  - PHYAD[4:0]
  - REGAD[4:0]
- TA, write: drive 1 then 0, oe=1.
- TA, read:
  - oe=0 for both bits.
  - Sample mdio_i in the second bit; a value of 1 sets the err flag.
- DATA, 16 bits MSB first:
  - Write: drive req_wdata, oe=1.
  - Read: oe=0; shift in sampled bits.
- DONE (1 cycle):
  - mdc_o=0, oe=0, mdio_o=1.
  - rsp_valid_o=1.
  - rsp_rdata_o = shifted data, or 16'hFFFF if err; 0 for writes.
  - rsp_err_o = err (always 0 for writes).
  - busy_o falls and req_ready_o rises on the following cycle, so a completion and an acceptance never share a cycle.
- Latency: rsp_valid_o is high at cycle T_accept + 1 + (PREAMBLE_LEN+32)*2*CLK_DIV. With default parameters that is T+3201.
- Between frames: MDC held low, MDIO released.
- Command inputs are ignored while req_ready_o=0; no queueing.
- Counters:
  - Divider counter: 10 bits, wraps at CLK_DIV-1.
  - Bit counter: 6 bits, reloaded per state; no overflow is possible within legal parameter ranges.

Decomposition:
- Package mdio_pkg holds:
  - ST_C=2'b01, OP_WR_C=2'b01, OP_RD_C=2'b10
  - HDR_BITS=14, DATA_BITS=16
  - state enum mdio_state_e
  - request struct mdio_req_t
- Sub-module mdio_clk_gen (parameter CLK_DIV):
  - Inputs: clk_i, rst_i, enable.
  - Outputs: mdc, fall_stb (first cycle of a bit period), sample_stb (last high cycle).
  - When disabled, holds mdc=0 and clears its counter.

Test Plan:
- Write, PHY=5'h01, REG=5'h00, data 16'h8000, CLK_DIV=2, PREAMBLE_LEN=32 -> bench captures 64 bits on MDC rising edges: 32 ones, 0101, 00001, 00000, 10, 1000_0000_0000_0000; oe=1 throughout; rsp_valid_o exactly at T+257; rsp_err_o=0.
- Read, PHY=5'h03, REG=5'h02; PHY model drives Z, 0 on TA then 16'h1234 -> oe=0 from TA onward; rsp_rdata_o=16'h1234, rsp_err_o=0.
- Read with no PHY (pull-up, mdio_i=1 throughout) -> rsp_err_o=1, rsp_rdata_o=16'hFFFF; next write completes with rsp_err_o=0.
- req_valid_i held high for two back-to-back writes -> second is accepted exactly 1 cycle after the first rsp_valid_o; its fields are unaffected by input changes during the first frame.
- rst_i pulsed during the DATA phase of a read -> next cycle mdc_o=0, mdio_oe_o=0, req_ready_o=1; no rsp_valid_o; a following read completes correctly.
- CLK_DIV=1, PREAMBLE_LEN=0 -> MDC toggles every cycle; 32-bit frame; rsp_valid_o at T+65.
